// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// reset/bubble defaults and the sequential-PC helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP        = 32'd4;

    // Plain 32-bit addition: 32'hFFFF_FFFC + 4 wraps to zero.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: 32-bit, load enable, asynchronous reset to RESET_PC.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs, regardless of process ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding IMem request FSM, stall holding
// buffer, redirect squash handling and the IF/ID pipeline register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] NOP_WORD = FETCH_NOP_WORD
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCSel,
    input  logic [31:0] BranchPC,
    input  logic        Stall_PC,
    input  logic [31:0] IMem_Data,
    input  logic        IMem_Ready,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] PC_Out
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pc_load;
    logic [31:0] pc_plus4;

    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q,   ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pend_pc_q,  pend_pc_d;
    logic        imem_req;

    assign pc_plus4 = next_seq_pc(pc_q);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .load_i (pc_load),
        .d_i    (pc_d),
        .q_o    (pc_q)
    );

    // NOTE: every variable driven here is given a default before the case
    // statement, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_load      = 1'b0;
        pc_d         = pc_plus4;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        hold_buf_d   = hold_buf_q;
        pend_pc_d    = pend_pc_q;
        imem_req     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end

            REQ: begin
                imem_req = 1'b1;
                if (PCSel) begin
                    // Redirect wins over stall; the word in flight is wrong-path.
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                    if (IMem_Ready) begin
                        pc_load = 1'b1;
                        pc_d    = BranchPC;
                    end else begin
                        pend_pc_d = BranchPC;
                        state_d   = SQUASH;
                    end
                end else if (IMem_Ready) begin
                    if (Stall_PC) begin
                        hold_buf_d = IMem_Data;
                        state_d    = HOLD;
                    end else begin
                        ifid_instr_d = IMem_Data;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                        pc_load      = 1'b1;
                    end
                end else if (!Stall_PC) begin
                    // Memory wait state: ID consumed the old word, feed it a bubble.
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (PCSel) begin
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                    pc_load      = 1'b1;
                    pc_d         = BranchPC;
                    state_d      = REQ;
                end else if (!Stall_PC) begin
                    ifid_instr_d = hold_buf_q;
                    ifid_pc4_d   = pc_plus4;
                    ifid_valid_d = 1'b1;
                    pc_load      = 1'b1;
                    state_d      = REQ;
                end
            end

            SQUASH: begin
                // Old-address request must complete before the target is fetched.
                imem_req     = 1'b1;
                ifid_instr_d = NOP_WORD;
                ifid_valid_d = 1'b0;
                if (PCSel) begin
                    pend_pc_d = BranchPC;
                end
                if (IMem_Ready) begin
                    pc_load = 1'b1;
                    pc_d    = PCSel ? BranchPC : pend_pc_q;
                    state_d = REQ;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the data-only registers (holding buffer, pending target) are reset
    // too; they are few and a known value keeps post-reset behaviour exact.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            hold_buf_q   <= 32'h0000_0000;
            pend_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            hold_buf_q   <= hold_buf_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    // Request is decoded from the asynchronously reset state, so it drops with Reset.
    assign IMem_Req         = imem_req;
    assign IMem_Addr        = pc_q;
    assign PC_Out           = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PCPlus4     = ifid_pc4_q;
    assign IFID_Valid       = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus a scoreboard
// of instruction words expected to reach IF/ID, and a mid-wait reset sequence.
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PCSel;
    logic [31:0] BranchPC;
    logic        Stall_PC;
    logic [31:0] IMem_Data;
    logic        IMem_Ready;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] PC_Out;

    fetch_unit #(
        .RESET_PC (TB_RESET_PC),
        .NOP_WORD (TB_NOP)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .PCSel            (PCSel),
        .BranchPC         (BranchPC),
        .Stall_PC         (Stall_PC),
        .IMem_Data        (IMem_Data),
        .IMem_Ready       (IMem_Ready),
        .IMem_Req         (IMem_Req),
        .IMem_Addr        (IMem_Addr),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .PC_Out           (PC_Out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        req;    // expected IMem_Req before the edge
        logic [31:0] addr;   // expected IMem_Addr before the edge
        logic        ready;
        logic        stall;
        logic        pcsel;
        logic [31:0] bpc;
        logic [31:0] pc;     // expected PC_Out after the edge
        logic        valid;  // expected IFID_Valid after the edge
        logic        acc;    // this response must eventually reach IF/ID
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] p4;
    } sb_t;

    vec_t        vecs[31];
    sb_t         sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_valid;
    logic [31:0] prev_instr;
    logic [31:0] prev_p4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ {a[31:16], 16'h0000};
    endfunction

    function automatic vec_t mk(input logic req, input logic [31:0] addr,
                                input logic ready, input logic stall,
                                input logic pcsel, input logic [31:0] bpc,
                                input logic [31:0] pc, input logic valid,
                                input logic acc);
        vec_t v;
        v.req = req;   v.addr = addr; v.ready = ready; v.stall = stall;
        v.pcsel = pcsel; v.bpc = bpc; v.pc = pc; v.valid = valid; v.acc = acc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input int idx, input vec_t v);
        sb_t  e;
        logic loaded;
        @(negedge Clk);
        PCSel      = v.pcsel;
        BranchPC   = v.bpc;
        Stall_PC   = v.stall;
        IMem_Ready = v.ready;
        IMem_Data  = v.ready ? mem_word(v.addr) : 32'hBAD0_BAD0;
        if (v.acc) begin
            e.instr = mem_word(v.addr);
            e.p4    = v.addr + 32'd4;
            sb.push_back(e);
        end
        #1;
        check($sformatf("v%0d imem_req", idx), {31'd0, IMem_Req}, {31'd0, v.req});
        check($sformatf("v%0d imem_addr", idx), IMem_Addr, v.addr);
        @(posedge Clk);
        #1;
        check($sformatf("v%0d pc", idx), PC_Out, v.pc);
        check($sformatf("v%0d ifid_valid", idx), {31'd0, IFID_Valid}, {31'd0, v.valid});
        if (!v.valid) begin
            check($sformatf("v%0d bubble_instr", idx), IFID_Instruction, TB_NOP);
        end
        loaded = IFID_Valid && (!prev_valid || IFID_PCPlus4 != prev_p4 ||
                                IFID_Instruction != prev_instr);
        if (loaded) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL v%0d sb_unexpected: got instr %h pc4 %h, want nothing",
                         idx, IFID_Instruction, IFID_PCPlus4);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d sb_instr", idx), IFID_Instruction, e.instr);
                check($sformatf("v%0d sb_pc4", idx), IFID_PCPlus4, e.p4);
            end
        end
        prev_valid = IFID_Valid;
        prev_instr = IFID_Instruction;
        prev_p4    = IFID_PCPlus4;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " imem_req"}, {31'd0, IMem_Req}, 32'd0);
        check({tag, " pc"}, PC_Out, TB_RESET_PC);
        check({tag, " ifid_valid"}, {31'd0, IFID_Valid}, 32'd0);
        check({tag, " ifid_instr"}, IFID_Instruction, TB_NOP);
        check({tag, " ifid_pc4"}, IFID_PCPlus4, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req addr           rdy stl sel bpc            pc_after       vld acc
        vecs[0]  = mk(0, 32'h0000_0000, 0, 0, 0, 32'h0,          32'h0000_0000, 0, 0);
        vecs[1]  = mk(1, 32'h0000_0000, 1, 0, 0, 32'h0,          32'h0000_0004, 1, 1);
        vecs[2]  = mk(1, 32'h0000_0004, 1, 0, 0, 32'h0,          32'h0000_0008, 1, 1);
        vecs[3]  = mk(1, 32'h0000_0008, 1, 0, 0, 32'h0,          32'h0000_000C, 1, 1);
        vecs[4]  = mk(1, 32'h0000_000C, 1, 0, 0, 32'h0,          32'h0000_0010, 1, 1);
        vecs[5]  = mk(1, 32'h0000_0010, 1, 1, 0, 32'h0,          32'h0000_0010, 1, 1);
        vecs[6]  = mk(0, 32'h0000_0010, 0, 1, 0, 32'h0,          32'h0000_0010, 1, 0);
        vecs[7]  = mk(0, 32'h0000_0010, 0, 1, 0, 32'h0,          32'h0000_0010, 1, 0);
        vecs[8]  = mk(0, 32'h0000_0010, 0, 0, 0, 32'h0,          32'h0000_0014, 1, 0);
        vecs[9]  = mk(1, 32'h0000_0014, 0, 1, 0, 32'h0,          32'h0000_0014, 1, 0);
        vecs[10] = mk(1, 32'h0000_0014, 0, 0, 0, 32'h0,          32'h0000_0014, 0, 0);
        vecs[11] = mk(1, 32'h0000_0014, 1, 0, 0, 32'h0,          32'h0000_0018, 1, 1);
        vecs[12] = mk(1, 32'h0000_0018, 1, 0, 1, 32'h0000_0008,  32'h0000_0008, 0, 0);
        vecs[13] = mk(1, 32'h0000_0008, 1, 0, 1, 32'h0000_0040,  32'h0000_0040, 0, 0);
        vecs[14] = mk(1, 32'h0000_0040, 1, 0, 0, 32'h0,          32'h0000_0044, 1, 1);
        vecs[15] = mk(1, 32'h0000_0044, 0, 0, 1, 32'h0000_0080,  32'h0000_0044, 0, 0);
        vecs[16] = mk(1, 32'h0000_0044, 0, 0, 0, 32'h0,          32'h0000_0044, 0, 0);
        vecs[17] = mk(1, 32'h0000_0044, 1, 0, 0, 32'h0,          32'h0000_0080, 0, 0);
        vecs[18] = mk(1, 32'h0000_0080, 0, 0, 0, 32'h0,          32'h0000_0080, 0, 0);
        vecs[19] = mk(1, 32'h0000_0080, 1, 0, 0, 32'h0,          32'h0000_0084, 1, 1);
        vecs[20] = mk(1, 32'h0000_0084, 1, 1, 1, 32'hFFFF_FFF8,  32'hFFFF_FFF8, 0, 0);
        vecs[21] = mk(1, 32'hFFFF_FFF8, 1, 0, 0, 32'h0,          32'hFFFF_FFFC, 1, 1);
        vecs[22] = mk(1, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,          32'h0000_0000, 1, 1);
        vecs[23] = mk(1, 32'h0000_0000, 1, 1, 0, 32'h0,          32'h0000_0000, 1, 0);
        vecs[24] = mk(0, 32'h0000_0000, 0, 1, 1, 32'h0000_0023,  32'h0000_0023, 0, 0);
        vecs[25] = mk(1, 32'h0000_0023, 1, 0, 0, 32'h0,          32'h0000_0027, 1, 1);
        vecs[26] = mk(1, 32'h0000_0027, 1, 0, 1, 32'h0000_001C,  32'h0000_001C, 0, 0);
        vecs[27] = mk(1, 32'h0000_001C, 1, 0, 0, 32'h0,          32'h0000_0020, 1, 1);
        vecs[28] = mk(1, 32'h0000_0020, 0, 1, 0, 32'h0,          32'h0000_0020, 1, 0);
        vecs[29] = mk(0, 32'h0000_0000, 1, 0, 0, 32'h0,          32'h0000_0000, 0, 0);
        vecs[30] = mk(1, 32'h0000_0000, 1, 0, 0, 32'h0,          32'h0000_0004, 1, 1);

        Reset      = 1'b1;
        PCSel      = 1'b0;
        BranchPC   = 32'h0;
        Stall_PC   = 1'b0;
        IMem_Data  = 32'h0;
        IMem_Ready = 1'b0;
        prev_valid = 1'b0;
        prev_instr = TB_NOP;
        prev_p4    = 32'h0;

        @(posedge Clk);
        #1;
        check_reset_state("por");
        Reset = 1'b0;

        for (int i = 0; i <= 28; i++) begin
            step(i, vecs[i]);
        end

        // Mid-wait reset at PC=0x20 with a late response arriving alongside it.
        #2;
        Reset      = 1'b1;
        IMem_Ready = 1'b1;
        IMem_Data  = mem_word(32'h0000_0020);
        #1;
        check_reset_state("async_rst");
        @(posedge Clk);
        #1;
        check_reset_state("rst_edge");
        Reset      = 1'b0;
        prev_valid = 1'b0;
        prev_instr = IFID_Instruction;
        prev_p4    = IFID_PCPlus4;

        for (int i = 29; i <= 30; i++) begin
            step(i, vecs[i]);
        end

        check("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
